// File: rtl/da_cache.sv
// Playback cache: packs 16-bit host words into 48-bit cache words in a ping-pong
// RAM and unpacks them as two 24-bit DAC samples per word at the sample-strobe rate.
module da_cache #(
    parameter int USB_DATA_NBIT = 16,
    parameter int DA_DATA_NBIT  = 16,
    parameter int CHE_ADDR_NBIT = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     wr,
    input  logic [USB_DATA_NBIT-1:0] wdata,
    output logic                     full,
    input  logic                     i_strobe,
    output logic                     o_strobe,
    output logic [DA_DATA_NBIT-1:0]  o_data,
    output logic                     switch,
    output logic                     underrun,
    output logic                     overflow
);
    localparam int DEPTH = 2 ** CHE_ADDR_NBIT;
    localparam logic [CHE_ADDR_NBIT-1:0] LAST = '1;

    typedef enum logic [1:0] {S_EMPTY, S_READ, S_LOAD, S_HOLD} state_t;

    logic [47:0]              pack_q, pack_d;
    logic [1:0]               cnt_q, cnt_d;
    logic                     wpend_q, wpend_d;
    logic [CHE_ADDR_NBIT-1:0] waddr_q, waddr_d;
    logic                     wsel_q, wsel_d;
    logic [1:0]               full_flags_q, full_flags_d;
    logic                     full_q, full_d;
    logic [CHE_ADDR_NBIT-1:0] raddr_q, raddr_d;
    logic                     rsel_q, rsel_d;
    state_t                   state_q, state_d;
    logic [47:0]              cur_q, cur_d;
    logic                     phase_q, phase_d;
    logic                     o_strobe_q, o_strobe_d;
    logic [DA_DATA_NBIT-1:0]  o_data_q, o_data_d;
    logic                     switch_q, switch_d;
    logic                     underrun_q, underrun_d;
    logic                     overflow_q, overflow_d;

    logic        ram_we, ram_re;
    logic [1:0]  full_set, full_clr;
    logic [47:0] mem [0:2*DEPTH-1];
    logic [47:0] ram_rdata_q;

    always_comb begin
        pack_d       = pack_q;
        cnt_d        = cnt_q;
        wpend_d      = 1'b0;
        waddr_d      = waddr_q;
        wsel_d       = wsel_q;
        raddr_d      = raddr_q;
        rsel_d       = rsel_q;
        state_d      = state_q;
        cur_d        = cur_q;
        phase_d      = phase_q;
        o_strobe_d   = 1'b0;
        o_data_d     = o_data_q;
        switch_d     = switch_q;
        underrun_d   = underrun_q;
        overflow_d   = overflow_q;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        full_set     = 2'b00;
        full_clr     = 2'b00;

        // Writer: words aimed at a full half are dropped without disturbing the packer.
        if (wr && full_flags_q[wsel_q]) begin
            overflow_d = 1'b1;
        end else if (wr) begin
            pack_d = {pack_q[31:0], wdata[15:0]};
            if (cnt_q == 2'd2) begin
                cnt_d   = 2'd0;
                wpend_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end

        if (wpend_q) begin
            ram_we  = 1'b1;
            waddr_d = waddr_q + 1'b1;
            if (waddr_q == LAST) begin
                full_set[wsel_q] = 1'b1;
                wsel_d           = ~wsel_q;
            end
        end

        case (state_q)
            S_EMPTY: begin
                if (full_flags_q[rsel_q]) begin
                    ram_re  = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_LOAD;
            S_LOAD: begin
                cur_d   = ram_rdata_q;
                phase_d = 1'b0;
                state_d = S_HOLD;
            end
            default: begin
                if (i_strobe) begin
                    if (!phase_q) begin
                        o_data_d = cur_q[47 -: DA_DATA_NBIT];
                        phase_d  = 1'b1;
                    end else begin
                        o_data_d = cur_q[23 -: DA_DATA_NBIT];
                        raddr_d  = raddr_q + 1'b1;
                        state_d  = S_EMPTY;
                        if (raddr_q == LAST) begin
                            full_clr[rsel_q] = 1'b1;
                            rsel_d           = ~rsel_q;
                            switch_d         = ~switch_q;
                        end
                    end
                end
            end
        endcase

        // A strobe with no loaded word still produces a (silent) sample.
        if (i_strobe) begin
            o_strobe_d = 1'b1;
            if (state_q != S_HOLD) begin
                o_data_d   = '0;
                underrun_d = 1'b1;
            end
        end

        full_flags_d = (full_flags_q & ~full_clr) | full_set;
        full_d       = full_flags_d[wsel_d];

        if (!en) begin
            pack_d       = '0;
            cnt_d        = 2'd0;
            wpend_d      = 1'b0;
            waddr_d      = '0;
            wsel_d       = 1'b0;
            full_flags_d = 2'b00;
            full_d       = 1'b0;
            raddr_d      = '0;
            rsel_d       = 1'b0;
            state_d      = S_EMPTY;
            cur_d        = '0;
            phase_d      = 1'b0;
            o_strobe_d   = 1'b0;
            o_data_d     = '0;
            switch_d     = 1'b0;
            underrun_d   = underrun_q;
            overflow_d   = overflow_q;
            ram_we       = 1'b0;
            ram_re       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pack_q       <= '0;
            cnt_q        <= 2'd0;
            wpend_q      <= 1'b0;
            waddr_q      <= '0;
            wsel_q       <= 1'b0;
            full_flags_q <= 2'b00;
            full_q       <= 1'b0;
            raddr_q      <= '0;
            rsel_q       <= 1'b0;
            state_q      <= S_EMPTY;
            cur_q        <= '0;
            phase_q      <= 1'b0;
            o_strobe_q   <= 1'b0;
            o_data_q     <= '0;
            switch_q     <= 1'b0;
            underrun_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            pack_q       <= pack_d;
            cnt_q        <= cnt_d;
            wpend_q      <= wpend_d;
            waddr_q      <= waddr_d;
            wsel_q       <= wsel_d;
            full_flags_q <= full_flags_d;
            full_q       <= full_d;
            raddr_q      <= raddr_d;
            rsel_q       <= rsel_d;
            state_q      <= state_d;
            cur_q        <= cur_d;
            phase_q      <= phase_d;
            o_strobe_q   <= o_strobe_d;
            o_data_q     <= o_data_d;
            switch_q     <= switch_d;
            underrun_q   <= underrun_d;
            overflow_q   <= overflow_d;
        end
    end

    // Simple dual-port RAM, read data valid one cycle after ram_re.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[{wsel_q, waddr_q}] <= pack_q;
        end
        if (ram_re) begin
            ram_rdata_q <= mem[{rsel_q, raddr_q}];
        end
    end

    assign full     = full_q;
    assign o_strobe = o_strobe_q;
    assign o_data   = o_data_q;
    assign switch   = switch_q;
    assign underrun = underrun_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_da_cache.sv
// Directed bench for da_cache: a word-level model pushes expected samples into a
// queue as host words are written; each DAC strobe pops and compares one sample.
module tb_da_cache;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        wr_v = 1'b0;
    logic [15:0] wdata_v = '0;
    logic        strobe_v = 1'b0;
    logic        sel16 = 1'b0;

    logic        full_a, o_strobe_a, switch_a, underrun_a, overflow_a;
    logic [23:0] o_data_a;
    logic        full_b, o_strobe_b, switch_b, underrun_b, overflow_b;
    logic [15:0] o_data_b;

    logic [23:0] exp_q[$];
    logic [15:0] mw [0:2];
    int          mcnt = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    da_cache #(.USB_DATA_NBIT(16), .DA_DATA_NBIT(24), .CHE_ADDR_NBIT(2)) dut (
        .clk(clk), .rst(rst), .en(en), .wr(wr_v & ~sel16), .wdata(wdata_v),
        .full(full_a), .i_strobe(strobe_v & ~sel16), .o_strobe(o_strobe_a),
        .o_data(o_data_a), .switch(switch_a), .underrun(underrun_a), .overflow(overflow_a)
    );

    da_cache #(.USB_DATA_NBIT(16), .DA_DATA_NBIT(16), .CHE_ADDR_NBIT(2)) dut16 (
        .clk(clk), .rst(rst), .en(en), .wr(wr_v & sel16), .wdata(wdata_v),
        .full(full_b), .i_strobe(strobe_v & sel16), .o_strobe(o_strobe_b),
        .o_data(o_data_b), .switch(switch_b), .underrun(underrun_b), .overflow(overflow_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_word(input logic [15:0] w);
        logic [23:0] s0, s1;
        mw[mcnt] = w;
        if (mcnt == 2) begin
            s0 = {mw[0], mw[1][15:8]};
            s1 = {mw[1][7:0], mw[2]};
            exp_q.push_back(sel16 ? {8'h00, s0[23:8]} : s0);
            exp_q.push_back(sel16 ? {8'h00, s1[23:8]} : s1);
            mcnt = 0;
        end else begin
            mcnt++;
        end
    endtask

    task automatic write_word(input logic [15:0] w, input bit accepted);
        wr_v    = 1'b1;
        wdata_v = w;
        tick();
        wr_v = 1'b0;
        if (accepted) model_word(w);
        tick();
    endtask

    // One strobe every 4 clocks; the sample must appear exactly one clock later.
    task automatic play(input string tag, input bit silent);
        logic [23:0] exp;
        logic [23:0] obs;
        strobe_v = 1'b1;
        tick();
        strobe_v = 1'b0;
        if (silent) begin
            exp = '0;
        end else if (exp_q.size() == 0) begin
            exp = '0;
            checks++;
            errors++;
            $display("FAIL %s: observed=sample expected=empty scoreboard", tag);
        end else begin
            exp = exp_q.pop_front();
        end
        obs = sel16 ? {8'h00, o_data_b} : o_data_a;
        check({tag, "_strobe"}, 32'(sel16 ? o_strobe_b : o_strobe_a), 32'd1);
        check({tag, "_data"}, 32'(obs), 32'(exp));
        tick();
        check({tag, "_strobe_end"}, 32'(sel16 ? o_strobe_b : o_strobe_a), 32'd0);
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        mcnt = 0;
    endtask

    initial begin
        do_reset();
        check("rst_o_strobe", 32'(o_strobe_a), 32'd0);
        check("rst_o_data", 32'(o_data_a), 32'd0);
        check("rst_switch", 32'(switch_a), 32'd0);
        check("rst_underrun", 32'(underrun_a), 32'd0);
        check("rst_overflow", 32'(overflow_a), 32'd0);
        check("rst_full", 32'(full_a), 32'd0);

        // Empty buffer: silent samples and a sticky underrun.
        play("empty0", 1'b1);
        check("underrun_set", 32'(underrun_a), 32'd1);
        play("empty1", 1'b1);
        tick();
        check("underrun_sticky", 32'(underrun_a), 32'd1);
        do_reset();
        check("underrun_rst", 32'(underrun_a), 32'd0);

        // Fill half 0 with byte pattern 00,11,22,... and play it back.
        for (int i = 0; i < 12; i++) begin
            write_word({8'(2 * i * 17), 8'((2 * i + 1) * 17)}, 1'b1);
            check("fill_full", 32'(full_a), 32'd0);
        end
        check("fill_wsel", 32'(dut.wsel_q), 32'd1);
        check("fill_flags", 32'(dut.full_flags_q), 32'd1);
        check("first_sample_model", 32'(exp_q[0]), 32'h001122);
        repeat (5) tick();
        for (int n = 0; n < 8; n++) begin
            play("half0", 1'b0);
            check("half0_underrun", 32'(underrun_a), 32'd0);
            check("half0_switch", 32'(switch_a), (n == 7) ? 32'd1 : 32'd0);
        end

        // Both halves full, 25th word dropped, refill of half 0 after release.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            write_word(16'h1000 + 16'(i * 16'h0101), 1'b1);
            if (i == 11) check("ovf_full_half", 32'(full_a), 32'd0);
        end
        check("ovf_full_both", 32'(full_a), 32'd1);
        check("ovf_pre", 32'(overflow_a), 32'd0);
        write_word(16'hDEAD, 1'b0);
        check("ovf_set", 32'(overflow_a), 32'd1);
        check("ovf_full_hold", 32'(full_a), 32'd1);
        check("ovf_cnt_hold", 32'(dut.cnt_q), 32'd0);
        repeat (2) tick();
        for (int n = 0; n < 8; n++) play("ovf_h0", 1'b0);
        check("ovf_freed", 32'(full_a), 32'd0);
        for (int i = 0; i < 12; i++) write_word(16'h5000 + 16'(i * 16'h0203), 1'b1);
        check("ovf_refill_flags", 32'(dut.full_flags_q), 32'd3);
        check("ovf_refill_full", 32'(full_a), 32'd1);
        for (int n = 0; n < 16; n++) play("ovf_drain", 1'b0);
        check("ovf_drained", 32'(exp_q.size()), 32'd0);
        check("ovf_sticky", 32'(overflow_a), 32'd1);
        check("ovf_no_underrun", 32'(underrun_a), 32'd0);

        // Drop en mid-half and mid-word; restart cleanly with fresh data.
        for (int i = 0; i < 12; i++) write_word(16'h7700 + 16'(i), 1'b1);
        repeat (5) tick();
        for (int n = 0; n < 4; n++) play("en_pre", 1'b0);
        write_word(16'hBEEF, 1'b0);
        check("en_cnt_pre", 32'(dut.cnt_q), 32'd1);
        en = 1'b0;
        tick();
        tick();
        check("en_cnt", 32'(dut.cnt_q), 32'd0);
        check("en_flags", 32'(dut.full_flags_q), 32'd0);
        check("en_state", 32'(dut.state_q), 32'd0);
        check("en_raddr", 32'(dut.raddr_q), 32'd0);
        check("en_waddr", 32'(dut.waddr_q), 32'd0);
        check("en_rsel", 32'(dut.rsel_q), 32'd0);
        check("en_wsel", 32'(dut.wsel_q), 32'd0);
        check("en_full", 32'(full_a), 32'd0);
        check("en_switch", 32'(switch_a), 32'd0);
        check("en_o_data", 32'(o_data_a), 32'd0);
        check("en_ovf_hold", 32'(overflow_a), 32'd1);
        exp_q.delete();
        mcnt = 0;
        en = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) write_word(16'hA000 + 16'(i * 16'h0111), 1'b1);
        repeat (5) tick();
        for (int n = 0; n < 8; n++) play("en_post", 1'b0);
        check("en_post_drained", 32'(exp_q.size()), 32'd0);
        check("en_post_underrun", 32'(underrun_a), 32'd0);

        // 16-bit DAC width keeps the top bits of each 24-bit sample.
        do_reset();
        sel16 = 1'b1;
        write_word(16'h8000, 1'b1);
        write_word(16'h0012, 1'b1);
        write_word(16'h3456, 1'b1);
        check("w16_model0", 32'(exp_q[0]), 32'h8000);
        check("w16_model1", 32'(exp_q[1]), 32'h1234);
        for (int i = 0; i < 9; i++) write_word(16'h0000, 1'b1);
        repeat (5) tick();
        play("w16_s0", 1'b0);
        play("w16_s1", 1'b0);
        check("w16_underrun", 32'(underrun_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
